// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with direct decode and timed scan modes.
// Scan walks the active output across all N outputs, DWELL cycles per step.
module onehot_decoder_seq #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    start,
  output logic [(1<<SEL_W)-1:0]   dout,
  output logic [SEL_W-1:0]        idx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned N    = 1 << SEL_W;
  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CntW-1:0]  CntMax  = CntW'(DWELL - 1);
  localparam logic [SEL_W-1:0] StepMax = SEL_W'(N - 1);
  localparam logic [N-1:0]     OneHot0 = N'(1);

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  // Number of completed steps in the current scan; the last step ends the scan.
  logic [SEL_W-1:0] step_q;
  logic [SEL_W-1:0] idx_inc;

  assign idx_inc = idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= '0;
      dout    <= '0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!en) begin
        // Abort anything in flight; idx deliberately holds its last value.
        state_q <= StIdle;
        cnt_q   <= '0;
        dout    <= '0;
        busy    <= 1'b0;
      end else if (!mode) begin
        state_q <= StDirect;
        cnt_q   <= '0;
        dout    <= OneHot0 << sel;
        idx     <= sel;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StDirect: begin
            if (start) begin
              state_q <= StScan;
              cnt_q   <= '0;
              step_q  <= '0;
              dout    <= OneHot0 << sel;
              idx     <= sel;
              busy    <= 1'b1;
            end else begin
              state_q <= StIdle;
              dout    <= '0;
              busy    <= 1'b0;
            end
          end
          StScan: begin
            // start is ignored here: a running scan never restarts.
            if (cnt_q == CntMax) begin
              cnt_q <= '0;
              if (step_q == StepMax) begin
                state_q <= StIdle;
                dout    <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                step_q <= step_q + SEL_W'(1);
                idx    <= idx_inc;
                dout   <= OneHot0 << idx_inc;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            dout    <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq: directed steps plus randomized scans,
// checked against an arithmetic model of the expected scan walk.
module tb_onehot_decoder_seq;

  localparam int AW = 2;
  localparam int AN = 4;
  localparam int AD = 2;
  localparam int BW = 3;
  localparam int BN = 8;
  localparam int BD = 1;

  logic          clk;
  logic          rst_n;

  logic          a_en, a_mode, a_start;
  logic [AW-1:0] a_sel, a_idx;
  logic [AN-1:0] a_dout;
  logic          a_busy, a_done;

  logic          b_en, b_mode, b_start;
  logic [BW-1:0] b_sel, b_idx;
  logic [BN-1:0] b_dout;
  logic          b_busy, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  onehot_decoder_seq #(.SEL_W(AW), .DWELL(AD)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (a_en),
    .mode  (a_mode),
    .sel   (a_sel),
    .start (a_start),
    .dout  (a_dout),
    .idx   (a_idx),
    .busy  (a_busy),
    .done  (a_done)
  );

  onehot_decoder_seq #(.SEL_W(BW), .DWELL(BD)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (b_en),
    .mode  (b_mode),
    .sel   (b_sel),
    .start (b_start),
    .dout  (b_dout),
    .idx   (b_idx),
    .busy  (b_busy),
    .done  (b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs must never be multi-hot.
  always @(negedge clk) begin
    chk("onehot_a", 64'($onehot0(a_dout)), 64'(1));
    chk("onehot_b", 64'($onehot0(b_dout)), 64'(1));
  end

  // Reference: k-th active cycle after start shows index (s + (k-1)/D) mod N.
  function automatic int scan_idx(input int s, input int k, input int n, input int d);
    return (s + (k - 1) / d) % n;
  endfunction

  // abort_kind: 0 none, 1 mode=0, 2 en=0, 3 async reset; applied after check k=abort_at.
  task automatic scan_a(input int s, input int abort_kind, input int abort_at,
                        input int poke_at);
    int cur;
    a_en = 1'b1; a_mode = 1'b1; a_sel = AW'(s); a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 1; k <= AN * AD + 2; k++) begin
      if (k <= AN * AD) begin
        cur = scan_idx(s, k, AN, AD);
        chk("scan_dout", 64'(a_dout), 64'(1) << cur);
        chk("scan_idx", 64'(a_idx), 64'(cur));
        chk("scan_busy", 64'(a_busy), 64'(1));
        chk("scan_nodone", 64'(a_done), 64'(0));
      end else if (k == AN * AD + 1) begin
        chk("end_dout", 64'(a_dout), 64'(0));
        chk("end_busy", 64'(a_busy), 64'(0));
        chk("end_done", 64'(a_done), 64'(1));
      end else begin
        chk("done_pulse_len", 64'(a_done), 64'(0));
        chk("idle_dout", 64'(a_dout), 64'(0));
      end
      if (abort_kind != 0 && k == abort_at) begin
        if (abort_kind == 1) begin
          a_mode = 1'b0; a_sel = 2'd1;
          tick();
          chk("abort_mode_dout", 64'(a_dout), 64'h2);
          chk("abort_mode_idx", 64'(a_idx), 64'(1));
          chk("abort_mode_busy", 64'(a_busy), 64'(0));
          chk("abort_mode_done", 64'(a_done), 64'(0));
          tick();
          chk("abort_mode_nodone", 64'(a_done), 64'(0));
        end else if (abort_kind == 2) begin
          a_en = 1'b0;
          tick();
          chk("abort_en_dout", 64'(a_dout), 64'(0));
          chk("abort_en_idx_hold", 64'(a_idx), 64'(cur));
          chk("abort_en_busy", 64'(a_busy), 64'(0));
          chk("abort_en_done", 64'(a_done), 64'(0));
          tick();
          chk("abort_en_nodone", 64'(a_done), 64'(0));
          a_en = 1'b1;
        end else begin
          rst_n = 1'b0;
          #1;
          chk("abort_rst_dout", 64'(a_dout), 64'(0));
          chk("abort_rst_idx", 64'(a_idx), 64'(0));
          chk("abort_rst_busy", 64'(a_busy), 64'(0));
          chk("abort_rst_done", 64'(a_done), 64'(0));
          #1 rst_n = 1'b1;
          tick();
          chk("abort_rst_nodone", 64'(a_done), 64'(0));
          chk("abort_rst_idle", 64'(a_dout), 64'(0));
        end
        return;
      end
      a_start = (k == poke_at);
      a_sel   = (k == poke_at) ? 2'd0 : AW'(s);
      tick();
    end
  endtask

  task automatic scan_b(input int s);
    b_en = 1'b1; b_mode = 1'b1; b_sel = BW'(s); b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 1; k <= BN * BD; k++) begin
      chk("b_scan_dout", 64'(b_dout), 64'(1) << scan_idx(s, k, BN, BD));
      chk("b_scan_busy", 64'(b_busy), 64'(1));
      chk("b_scan_nodone", 64'(b_done), 64'(0));
      tick();
    end
    chk("b_end_dout", 64'(b_dout), 64'(0));
    chk("b_end_done", 64'(b_done), 64'(1));
    tick();
    chk("b_done_pulse_len", 64'(b_done), 64'(0));
  endtask

  initial begin
    int v;
    rst_n = 1'b0;
    a_en = 1'b0; a_mode = 1'b0; a_sel = '0; a_start = 1'b0;
    b_en = 1'b0; b_mode = 1'b0; b_sel = '0; b_start = 1'b0;
    #12;
    chk("rst_dout", 64'(a_dout), 64'(0));
    chk("rst_idx", 64'(a_idx), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));
    chk("rst_done", 64'(a_done), 64'(0));
    rst_n = 1'b1;

    // Direct decode, one cycle latency.
    a_en = 1'b1; a_mode = 1'b0;
    for (int s = 0; s < AN; s++) begin
      a_sel = AW'(s);
      tick();
      chk("direct_dout", 64'(a_dout), 64'(1) << s);
      chk("direct_idx", 64'(a_idx), 64'(s));
      chk("direct_busy", 64'(a_busy), 64'(0));
      chk("direct_done", 64'(a_done), 64'(0));
    end

    // Enable gating with idx hold.
    a_sel = 2'd3;
    tick();
    chk("gate_pre", 64'(a_dout), 64'h8);
    a_en = 1'b0;
    tick();
    chk("gate_off_dout", 64'(a_dout), 64'(0));
    chk("gate_off_idx", 64'(a_idx), 64'(3));
    a_en = 1'b1;
    tick();
    chk("gate_on_dout", 64'(a_dout), 64'h8);

    // Full scan with wrap, with an ignored start at cycle 3.
    scan_a(2, 0, 0, 3);
    // Aborts.
    scan_a(2, 1, 3, 0);
    scan_a(2, 2, 4, 0);
    scan_a(2, 3, 5, 0);

    // Randomized mix of direct steps and scans with optional aborts/restarts.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        a_en = 1'b1; a_mode = 1'b0;
        repeat (3) begin
          v = int'($urandom_range(0, AN - 1));
          a_sel = AW'(v);
          tick();
          chk("rand_direct_dout", 64'(a_dout), 64'(1) << v);
          chk("rand_direct_idx", 64'(a_idx), 64'(v));
        end
      end else begin
        scan_a(int'($urandom_range(0, AN - 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, AN * AD)), int'($urandom_range(1, AN * AD - 1)));
      end
    end
    a_en = 1'b0;

    // Wider select, single-cycle dwell.
    scan_b(7);
    for (int it = 0; it < 3; it++) scan_b(int'($urandom_range(0, BN - 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Parametrised, registered successor to the team's 2-to-4 enable decoder: SEL_W-bit select to N = 2^SEL_W one-hot outputs.
- Two modes. Direct mode: registered decode of sel, gated by en. Scan mode: the active output walks across all N outputs, DWELL cycles per step, with busy/done status.
- Drives select/strobe lines (LED banks, row enables, chip selects) from control logic.

Parameters:
- SEL_W, 2, select width; output count N = 2^SEL_W (legal 1..6).
- DWELL, 4, clock cycles each output stays active in scan mode (legal >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset.
- en  input  1  global enable; 0 forces all outputs low.
- mode  input  1  0 = direct decode, 1 = scan.
- sel  input  SEL_W  direct-mode index; start index in scan mode.
- start  input  1  single-cycle pulse that starts a scan (mode=1).
- dout  output  N  one-hot decoded outputs, registered.
- idx  output  SEL_W  index of the active output, registered.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when a scan completes normally.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: dout=0, idx=0, busy=0, done=0, state IDLE, dwell counter=0.
- All outputs are registered. Latency from input to dout is one clock.
- dout is at most one-hot at every cycle, never multi-hot.
- States: IDLE, DIRECT, SCAN.
- Priority, highest first: rst_n, en=0, mode, start.
- Any state, en=0: next state IDLE; dout<=0, busy<=0, done<=0; idx holds. Any scan in progress is aborted with no done pulse.
- en=1, mode=0, any state: next state DIRECT; dout<=1<<sel, idx<=sel, busy<=0. sel changes are tracked every cycle.
- A scan aborted by mode=0 gives no done pulse.
- IDLE or DIRECT, en=1, mode=1, start=0: next state IDLE, dout<=0.
- IDLE or DIRECT, en=1, mode=1, start=1: next state SCAN; dout<=1<<sel, idx<=sel, busy<=1, dwell counter<=0.
- SCAN, en=1, mode=1:
  - The dwell counter increments each cycle.
  - When it reaches DWELL-1, it clears and idx advances by 1, modulo N (N-1 wraps to 0). dout follows idx.
  - After N steps of DWELL cycles each (N*DWELL cycles from the first active cycle), next state IDLE: dout<=0, busy<=0, done<=1 for exactly one cycle.
- start while in SCAN: ignored; the scan does not restart.
- SEL_W=1, N=2: same rules apply; idx wraps 1->0.
- DWELL=1: idx advances every cycle.
- Reset asserted mid-scan: all outputs clear immediately (asynchronous). No done pulse.

Test Plan:
- Parameters SEL_W=2, DWELL=2 unless stated.
- Reset then direct: rst_n low then high; en=1, mode=0; sel=0,1,2,3 on successive cycles -> dout=0001,0010,0100,1000, each one cycle after its sel; busy=0 and done=0 throughout.
- Enable gating: direct mode sel=3 with dout=1000; drop en=0 -> next cycle dout=0000, idx stays 3; raise en=1 -> dout=1000 the following cycle.
- Full scan with wrap: en=1, mode=1, sel=2, start pulse -> dout=0100 for 2 cycles, then 1000 x2, 0001 x2, 0010 x2; next cycle dout=0000, busy=0, done=1 for one cycle; busy=1 over the 8 active cycles.
- Ignored restart: during the scan above, pulse start with sel=0 at cycle 3 -> sequence unchanged; done still at cycle 9.
- Aborts: mid-scan set mode=0 with sel=1 -> next cycle dout=0010, busy=0, no done ever. Repeat the scan and pull en=0 -> dout=0000, busy=0, no done. Repeat and assert rst_n=0 -> outputs clear without waiting for a clock edge.
- Parameter sweep: SEL_W=3, DWELL=1, sel=7, start -> dout walks 0x80,0x01,0x02 through 0x40, one per cycle; done on the 9th cycle after start. Assert dout one-hot or zero every cycle.
